calc_mul_sched: RTL

Round-robin scheduler that shares one W×W multiplier datapath among NUM_REQ requester FIFOs in the calc_ops example. Each job is two operand packets (A, then B) popped from one requester FIFO. The 2W-bit product is written to a single output FIFO as two packets, upper half first, each tagged with the requester index. It sits between the RAH per-channel read FIFOs and the shared result write FIFO.

---
 rtl/calc_ops_pkg.sv | 22 ++
 rtl/calc_rr_arbiter.sv | 32 +++
 rtl/calc_mul_sched.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/calc_ops_pkg.sv
// Shared definitions for the calc_ops schedulers: state encoding, default
// packet width and the order in which the two result halves are written.
package calc_ops_pkg;

  localparam int unsigned RAH_PACKET_WIDTH_DEF = 48;

  // Upper product half is pushed first, lower half second.
  localparam bit RESULT_HI_FIRST = 1'b1;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_A   = 4'd1,
    CAP_A  = 4'd2,
    WAIT_B = 4'd3,
    RD_B   = 4'd4,
    CAP_B  = 4'd5,
    MUL    = 4'd6,
    WR_HI  = 4'd7,
    WR_LO  = 4'd8
  } calc_state_e;

endpackage

// File: rtl/calc_rr_arbiter.sv
// Combinational round-robin arbiter: searches the request vector starting just
// after last_grant, wrapping, and returns a one-hot grant plus its index.
module calc_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [TAG_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int unsigned idx;

  // First requester after last_grant in circular order wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = (32'(last_grant) + off) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = TAG_W'(idx);
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_mul_sched.sv
// Round-robin scheduler sharing one WxW multiplier among NUM_REQ requester
// FIFOs. Each job pops operand A then B from one FIFO and writes the 2W-bit
// product to the output FIFO as two tagged packets, upper half first.
// Build option: define CALC_MUL_SIGNED_EN for a two's-complement multiply.
module calc_mul_sched
  import calc_ops_pkg::*;
#(
  parameter int unsigned RAH_PACKET_WIDTH = RAH_PACKET_WIDTH_DEF,
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned TAG_W            = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_empty,
  input  logic [NUM_REQ*RAH_PACKET_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_rden,
  input  logic                          out_full,
  output logic [RAH_PACKET_WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          out_wren,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned W = RAH_PACKET_WIDTH;

  calc_state_e          state_q, state_d;
  logic [TAG_W-1:0]     grant_q, grant_d;
  logic [TAG_W-1:0]     last_q, last_d;
  logic [W-1:0]         da_q, da_d, db_q, db_d;
  logic [2*W-1:0]       prod_q, prod_d;
  logic [NUM_REQ-1:0]   rden_d;
  logic [W-1:0]         odata_d;
  logic [TAG_W-1:0]     otag_d;
  logic                 wren_d, done_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [TAG_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [W-1:0]         cur_data;
  logic [2*W-1:0]       mul_res;
  logic [W-1:0]         first_half, second_half;

  calc_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .TAG_W  (TAG_W)
  ) u_arb (
    .req        (~req_empty),
    .last_grant (last_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .grant_valid(arb_valid)
  );

  assign grant_oh = NUM_REQ'(1) << grant_q;
  assign cur_data = req_data[32'(grant_q) * W +: W];

`ifdef CALC_MUL_SIGNED_EN
  assign mul_res = {{W{da_q[W-1]}}, da_q} * {{W{db_q[W-1]}}, db_q};
`else
  assign mul_res = {{W{1'b0}}, da_q} * {{W{1'b0}}, db_q};
`endif

  assign first_half  = RESULT_HI_FIRST ? prod_q[2*W-1:W] : prod_q[W-1:0];
  assign second_half = RESULT_HI_FIRST ? prod_q[W-1:0]   : prod_q[2*W-1:W];
  assign busy        = (state_q != IDLE);

  // Next-state and registered-output decode; pulses default low every cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    da_d    = da_q;
    db_d    = db_q;
    prod_d  = prod_q;
    rden_d  = '0;
    odata_d = out_data;
    otag_d  = out_tag;
    wren_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_idx;
          rden_d  = arb_grant;
          state_d = RD_A;
        end
      end
      RD_A: state_d = CAP_A;
      CAP_A: begin
        da_d = cur_data;
        if (!req_empty[grant_q]) begin
          rden_d  = grant_oh;
          state_d = RD_B;
        end else begin
          state_d = WAIT_B;
        end
      end
      // Grant is held here; no other requester is served until B shows up.
      WAIT_B: begin
        if (!req_empty[grant_q]) begin
          rden_d  = grant_oh;
          state_d = RD_B;
        end
      end
      RD_B: state_d = CAP_B;
      CAP_B: begin
        db_d    = cur_data;
        state_d = MUL;
      end
      MUL: begin
        prod_d  = mul_res;
        state_d = WR_HI;
      end
      WR_HI: begin
        if (!out_full) begin
          odata_d = first_half;
          otag_d  = grant_q;
          wren_d  = 1'b1;
          state_d = WR_LO;
        end
      end
      WR_LO: begin
        if (!out_full) begin
          odata_d = second_half;
          otag_d  = grant_q;
          wren_d  = 1'b1;
          done_d  = 1'b1;
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= TAG_W'(NUM_REQ - 1);
      da_q     <= '0;
      db_q     <= '0;
      prod_q   <= '0;
      req_rden <= '0;
      out_data <= '0;
      out_tag  <= '0;
      out_wren <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      da_q     <= da_d;
      db_q     <= db_d;
      prod_q   <= prod_d;
      req_rden <= rden_d;
      out_data <= odata_d;
      out_tag  <= otag_d;
      out_wren <= wren_d;
      done     <= done_d;
    end
  end

endmodule
